// File: rtl/galois_lfsr_stream_if.sv
// Word-stream bundle for galois_lfsr_stream: control strobes in, LFSR word plus status out.
// The master side drives the requests and the slave side produces the stream.
interface galois_lfsr_stream_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_seed;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             lockup_err;

    modport slave (
        input  en, load, load_seed, out_ready,
        output out_valid, out_data, wrap, period, lockup_err
    );

    modport master (
        output en, load, load_seed, out_ready,
        input  out_valid, out_data, wrap, period, lockup_err
    );
endinterface

// File: rtl/galois_lfsr_stream.sv
// Galois LFSR word source with valid/ready backpressure, guarded seed loading
// and period measurement against the last applied seed.
module galois_lfsr_stream #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h71,
    parameter logic [WIDTH-1:0] SEED  = 8'hE1,
    parameter int               STEP  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    galois_lfsr_stream_if.slave    bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             out_valid_q, out_valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_err_q, lockup_err_d;

    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] safe_seed;
    logic             adv;

    function automatic logic [WIDTH-1:0] lfsrShift(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : {WIDTH{1'b0}});
    endfunction

    always_comb begin
        stepped = state_q;
        for (int i = 0; i < STEP; i++) begin
            stepped = lfsrShift(stepped);
        end
    end

    // An all-zero seed would freeze the register forever, so it is swapped for SEED.
    assign safe_seed = (bus.load_seed == {WIDTH{1'b0}}) ? SEED : bus.load_seed;
    assign adv       = bus.en & ~bus.load & (bus.out_ready | ~out_valid_q);

    always_comb begin
        state_d      = state_q;
        ref_seed_d   = ref_seed_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        out_valid_d  = out_valid_q;
        wrap_d       = 1'b0;
        lockup_err_d = 1'b0;
        if (bus.load) begin
            state_d      = safe_seed;
            ref_seed_d   = safe_seed;
            cnt_d        = {WIDTH{1'b0}};
            out_valid_d  = 1'b0;
            lockup_err_d = (bus.load_seed == {WIDTH{1'b0}});
        end else if (adv) begin
            state_d     = stepped;
            out_valid_d = 1'b1;
            if (stepped == ref_seed_q) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + ONE;
                cnt_d    = {WIDTH{1'b0}};
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SEED;
            ref_seed_q   <= SEED;
            cnt_q        <= {WIDTH{1'b0}};
            period_q     <= {WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            wrap_q       <= 1'b0;
            lockup_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_seed_q   <= ref_seed_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            out_valid_q  <= out_valid_d;
            wrap_q       <= wrap_d;
            lockup_err_q <= lockup_err_d;
        end
    end

    assign bus.out_data   = state_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.wrap       = wrap_q;
    assign bus.period     = period_q;
    assign bus.lockup_err = lockup_err_q;

endmodule

// File: doc/galois_lfsr_stream.md
# galois_lfsr_stream

Parametrised Galois LFSR pseudo-random source for the DSP testbench. It supports configurable width, feedback polynomial, and number of shifts per advance. Output is a valid/ready word stream. The block also provides runtime seed loading, zero-seed lock-up protection, and period measurement. It feeds noise/dither generators and stimulus paths that must tolerate downstream backpressure.

## Interface
- WIDTH, 8, state and output width in bits (≥ 3).
- TAPS, 8'h71, feedback mask: bit i set means the old MSB is XORed into new bit i after the left shift. TAPS[0] must be 1. The default gives x^8+x^6+x^5+x^4+1.
- SEED, 8'hE1, reset and fallback state. Must be nonzero.
- STEP, 1, single-bit shifts applied per advance (1..WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  advance request.
- load  in  1  seed-load strobe.
- load_seed  in  WIDTH  seed value used when load=1.
- out_ready  in  1  downstream accepts out_data.
- out_valid  out  1  out_data holds a fresh, unconsumed word.
- out_data  out  WIDTH  current LFSR state.
- wrap  out  1  one-cycle pulse: the state just returned to the reference seed.
- period  out  WIDTH  advances between the last two returns to the reference seed.
- lockup_err  out  1  one-cycle pulse: a zero seed was loaded and replaced.

## Operation
- Single shift: nxt = {s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? TAPS : 0). One advance applies this STEP times, combinationally unrolled.
- Registers:
  - state.
  - ref_seed (last seed applied).
  - cnt (WIDTH bits, advances since ref_seed).
  - period.
  - out_valid, wrap, lockup_err.
- adv = en & rst_n & ~load & (out_ready | ~out_valid).
- Priority is reset > load > advance > consume.
- Reset (rst_n=0 at a clock edge): state=SEED, ref_seed=SEED, cnt=0, period=0, out_valid=0, wrap=0, lockup_err=0.
- Load:
  - state and ref_seed take load_seed, or SEED if load_seed==0. A zero seed also sets lockup_err=1 for one cycle.
  - cnt=0, out_valid=0, wrap=0. The in-flight word is dropped.
  - period is unchanged.
- Advance:
  - state takes step^STEP(state), and out_valid=1.
  - If the new state equals ref_seed: wrap=1, period=cnt+1, cnt=0.
  - Otherwise: cnt=cnt+1, wrap=0.
- No advance with out_ready=1: out_valid=0. With out_ready=0: out_valid holds and state holds.
- Words are never lost or duplicated under backpressure. Each word is presented until it is accepted (out_valid & out_ready).
- State can never reach zero from nonzero because TAPS[0]=1. The only lock-up entry point is load, and load is guarded.
- cnt cannot overflow: the period is at most 2^WIDTH−1. For STEP>1, wrap fires only on advance boundaries, so the measured period is in advances, not shifts.

## Timing
- All outputs are registered. out_data = state directly, with no extra pipeline stage.
- Advance latency is 1 cycle: en sampled at edge k gives the new out_data and out_valid after edge k.
- wrap and lockup_err assert for exactly one cycle after the causing edge. period updates on the same edge as wrap.
- load and en in the same cycle: load wins, with no advance that cycle.
- en=1 with out_ready held 1 gives one new word every cycle (full throughput).
- A mid-run reset overrides load and advance in the same cycle. The next word after release is step^STEP(SEED).

## Test plan
- Reset, then en=1, out_ready=1: out_valid=0 during reset. The sequence after release is 0xB3, 0x17, 0x2E, one per cycle.
- STEP=2, from reset with one advance: out_data=0x17. Then assert that each subsequent word equals two single steps of a reference model.
- Period: run 255 accepted advances after reset. wrap pulses exactly once, on the 255th advance, with out_data=0xE1 and period=255. The next wrap follows 255 advances later.
- Backpressure: out_ready low for 5 cycles with en=1. out_data holds at 0xB3 and out_valid stays 1. After out_ready rises, 0x17 appears next, with no skipped word.
- Load: load=1, load_seed=0x01 with en=1. out_valid=0, and the next word is 0x02. Then load_seed=0x00: lockup_err pulses, the state becomes 0xE1, and the next word is 0xB3.
- Reset mid-stream asserted alongside load=1: after release, state=0xE1, cnt=0, period=0, wrap=0, and the first word is 0xB3.
